rng_health_monitor: RTL and testbench
=====================================

// Module: rng_health_monitor
// PURPOSE
//  Sits directly downstream of the parity-filter byte generator, on low_Freq_Clk.
//  Runs SP 800-90B-style continuous health tests (RCT and APT) on each qualified random byte.
//  Buffers approved bytes in a small FIFO and presents them to the consumer over valid/ready.
//  Raises sticky alarms and withholds all output while the source is unhealthy.
// PARAMETERS
//  RCT_CUTOFF  4    repetition-count fail threshold; run length of identical bytes that fails
//  APT_WINDOW  512  adaptive-proportion window length in samples; power of two, >=4
//  APT_CUTOFF  13   reference-byte match count within one window that fails
//  FIFO_DEPTH  4    output buffer entries; power of two
// PORTS
//  low_Freq_Clk  in   1  sole clock, rising edge
//  reset         in   1  asynchronous, active-low
//  in_Valid      in   1  in_Byte is a fresh sample this cycle (driven from random_On)
//  in_Byte       in   8  random byte from upstream filter bank
//  alarm_Clear   in   1  one-cycle pulse; clears alarms and restarts startup test
//  out_Ready     in   1  consumer accepts out_Byte this cycle
//  out_Valid     out  1  out_Byte holds a buffered approved byte
//  out_Byte      out  8  head of FIFO
//  fifo_Count    out  log2(FIFO_DEPTH)+1  current occupancy
//  health_Ok     out  1  high only in RUN state
//  rct_Fail      out  1  sticky RCT alarm
//  apt_Fail      out  1  sticky APT alarm
//  overflow      out  1  sticky: an approved byte was dropped because FIFO was full
// BEHAVIOUR
//  Reset: state=STARTUP; all outputs 0; FIFO empty; rep count=0; window count=0.
//  States: STARTUP -> RUN -> FAIL -> (alarm_Clear) -> STARTUP. alarm_Clear in STARTUP or RUN also restarts STARTUP.
//  Tests run only on cycles with in_Valid=1. They run in STARTUP and RUN and are frozen in FAIL.
//  RCT:
//   - first sample after reset or clear: last=in_Byte, rep=1
//   - each later sample: rep=rep+1 if in_Byte==last, else rep=1; last=in_Byte
//   - rep reaching RCT_CUTOFF sets rct_Fail
//  APT:
//   - window index 0 latches ref=in_Byte, match=1
//   - each later sample in the window increments match if in_Byte==ref
//   - match reaching APT_CUTOFF sets apt_Fail
//   - index wraps APT_WINDOW-1 -> 0; the next sample becomes the new ref
//  Any fail: state=FAIL at the same edge. The failing sample is never pushed.
//   The FIFO is flushed at that edge: out_Valid=0 and fifo_Count=0 from the next cycle.
//  STARTUP: samples are tested but discarded.
//   Completing the first full window (index APT_WINDOW-1) with no fail -> RUN. That sample is also discarded.
//   health_Ok rises the cycle after.
//  RUN: a passing sample is pushed if fifo_Count<FIFO_DEPTH, or if a pop occurs the same cycle.
//   Otherwise it is dropped and overflow is set.
//  FAIL: in_Valid ignored; no pushes; out_Valid=0; counters held.
//   Leaves only on alarm_Clear, which clears rct_Fail, apt_Fail, overflow, rep and window count.
//  alarm_Clear has priority over a fail detected on the same cycle. That sample is discarded.
//  FIFO:
//   - registered show-ahead; out_Valid=(count!=0)
//   - pop = out_Valid & out_Ready
//   - a byte pushed at edge N into an empty FIFO is visible at out_Byte from N+1
//   - pointers wrap modulo FIFO_DEPTH
//   - out_Byte holds its value while out_Valid=1 and out_Ready=0
//  Mid-operation reset returns to the reset values immediately (asynchronous).
// STRUCTURE
//  rng_pkg: state encodings (STARTUP/RUN/FAIL) and default cutoff constants.
//  Sub-module rng_byte_fifo: parameterised synchronous FIFO with push, pop, flush and count.
//  Health tests and FSM live in the top level.
// TESTING  (bench overrides: APT_WINDOW=16, APT_CUTOFF=6, RCT_CUTOFF=4, FIFO_DEPTH=4)
//  Startup: 16 distinct bytes 0x00..0x0F, out_Ready=1
//   -> no output; health_Ok=1 after the 16th; next byte 0x10 appears on out_Byte one cycle later.
//  RCT: in RUN, feed 0xA5 x4 consecutively
//   -> rct_Fail=1 on the 4th; first three 0xA5 are output; 4th is not; FIFO flushed; health_Ok=0.
//  APT: in RUN, window ref 0x3C, then 0x3C in 5 of the next 15 samples, spaced apart
//   -> apt_Fail=1 on the 6th match; RCT stays 0.
//  Backpressure: out_Ready=0, 6 distinct bytes in RUN
//   -> fifo_Count=4, overflow=1; out_Ready=1 drains bytes 1-4 in order.
//  Simultaneous push and pop at full with out_Ready=1 -> count stays 4; no overflow.
//  Recovery: alarm_Clear in FAIL -> all flags 0, STARTUP; 16 clean samples -> RUN.
//  Async reset asserted mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/rng_pkg.sv
// rng_pkg: state encodings and default thresholds for the RNG health monitor
package rng_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_FAIL    = 2'd2
    } rng_state_e;

    localparam int RCT_CUTOFF_DEF = 4;
    localparam int APT_WINDOW_DEF = 512;
    localparam int APT_CUTOFF_DEF = 13;
    localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/rng_byte_fifo.sv
// rng_byte_fifo: show-ahead synchronous byte FIFO with flush and occupancy count
module rng_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          pop_ok, push_ok;

    assign valid   = cnt_q != '0;
    assign full    = cnt_q == CW'(DEPTH);
    assign count   = cnt_q;
    assign pop_ok  = pop && valid;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign dout    = valid ? mem_q[rd_q] : '0;

    // storage array; contents are only observable through valid-gated dout
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

    // pointers and occupancy; flush empties the buffer in one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push_ok ? wr_q + AW'(1) : wr_q;
            rd_q  <= pop_ok ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/rng_health_monitor.sv
// rng_health_monitor: RCT/APT continuous health tests gating random bytes into an output FIFO
module rng_health_monitor
    import rng_pkg::*;
#(
    parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
    parameter int APT_WINDOW = APT_WINDOW_DEF,
    parameter int APT_CUTOFF = APT_CUTOFF_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          low_Freq_Clk,
    input  logic                          reset,
    input  logic                          in_Valid,
    input  logic [7:0]                    in_Byte,
    input  logic                          alarm_Clear,
    input  logic                          out_Ready,
    output logic                          out_Valid,
    output logic [7:0]                    out_Byte,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_Count,
    output logic                          health_Ok,
    output logic                          rct_Fail,
    output logic                          apt_Fail,
    output logic                          overflow
);

    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int IW = $clog2(APT_WINDOW);
    localparam int MW = $clog2(APT_CUTOFF + 1);

    rng_state_e    state_q, state_d;
    logic [7:0]    last_q, last_d, ref_q, ref_d;
    logic [RW-1:0] rep_q, rep_d, rep_n;
    logic [MW-1:0] match_q, match_d, match_n;
    logic [IW-1:0] idx_q, idx_d;
    logic          rct_q, rct_d, apt_q, apt_d, ovf_q, ovf_d;
    logic          rct_hit, apt_hit, test, push, pop, flush, full;

    assign pop       = out_Valid && out_Ready;
    assign health_Ok = state_q == ST_RUN;
    assign rct_Fail  = rct_q;
    assign apt_Fail  = apt_q;
    assign overflow  = ovf_q;

    // health tests, state transitions and push/flush decisions for this sample
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ref_d   = ref_q;
        rep_d   = rep_q;
        match_d = match_q;
        idx_d   = idx_q;
        rct_d   = rct_q;
        apt_d   = apt_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        flush   = 1'b0;
        test    = in_Valid && state_q != ST_FAIL;
        rep_n   = (rep_q != '0 && in_Byte == last_q) ? rep_q + RW'(1) : RW'(1);
        match_n = (idx_q == '0) ? MW'(1) : match_q + MW'(in_Byte == ref_q);
        rct_hit = rep_n == RW'(RCT_CUTOFF);
        apt_hit = match_n == MW'(APT_CUTOFF);
        if (alarm_Clear) begin
            state_d = ST_STARTUP;
            rep_d   = '0;
            match_d = '0;
            idx_d   = '0;
            rct_d   = 1'b0;
            apt_d   = 1'b0;
            ovf_d   = 1'b0;
        end else if (test) begin
            last_d  = in_Byte;
            ref_d   = (idx_q == '0) ? in_Byte : ref_q;
            rep_d   = rep_n;
            match_d = match_n;
            idx_d   = idx_q + IW'(1);
            if (rct_hit || apt_hit) begin
                state_d = ST_FAIL;
                rct_d   = rct_q || rct_hit;
                apt_d   = apt_q || apt_hit;
                flush   = 1'b1;
            end else if (state_q == ST_STARTUP) begin
                state_d = (idx_q == IW'(APT_WINDOW - 1)) ? ST_RUN : ST_STARTUP;
            end else if (full && !pop) begin
                ovf_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
    end

    // state and health-test registers
    always_ff @(posedge low_Freq_Clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STARTUP;
            last_q  <= '0;
            ref_q   <= '0;
            rep_q   <= '0;
            match_q <= '0;
            idx_q   <= '0;
            rct_q   <= 1'b0;
            apt_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ref_q   <= ref_d;
            rep_q   <= rep_d;
            match_q <= match_d;
            idx_q   <= idx_d;
            rct_q   <= rct_d;
            apt_q   <= apt_d;
            ovf_q   <= ovf_d;
        end
    end

    rng_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (low_Freq_Clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_Byte),
        .dout  (out_Byte),
        .count (fifo_Count),
        .valid (out_Valid),
        .full  (full)
    );

endmodule

// File: tb/tb_rng_health_monitor.sv
// tb_rng_health_monitor: directed checks of startup, RCT, APT, backpressure, recovery and async reset
module tb_rng_health_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_Valid = 1'b0;
    logic [7:0] in_Byte = '0;
    logic       alarm_Clear = 1'b0;
    logic       out_Ready = 1'b0;
    logic       out_Valid;
    logic [7:0] out_Byte;
    logic [2:0] fifo_Count;
    logic       health_Ok, rct_Fail, apt_Fail, overflow;
    int         total = 0;
    int         bad = 0;

    rng_health_monitor #(
        .RCT_CUTOFF(4), .APT_WINDOW(16), .APT_CUTOFF(6), .FIFO_DEPTH(4)
    ) dut (
        .low_Freq_Clk (clk),
        .reset        (reset),
        .in_Valid     (in_Valid),
        .in_Byte      (in_Byte),
        .alarm_Clear  (alarm_Clear),
        .out_Ready    (out_Ready),
        .out_Valid    (out_Valid),
        .out_Byte     (out_Byte),
        .fifo_Count   (fifo_Count),
        .health_Ok    (health_Ok),
        .rct_Fail     (rct_Fail),
        .apt_Fail     (apt_Fail),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic clr);
        in_Valid    = v;
        in_Byte     = b;
        alarm_Clear = clr;
        @(posedge clk);
        #1;
        in_Valid    = 1'b0;
        alarm_Clear = 1'b0;
    endtask

    task automatic startup(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, base + 8'(i), 1'b0);
            chk("startup_no_out", {31'd0, out_Valid}, 0);
            chk("startup_health", {31'd0, health_Ok}, (i == 15) ? 1 : 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_health", {31'd0, health_Ok}, 0);
        chk("rst_valid", {31'd0, out_Valid}, 0);
        chk("rst_count", {29'd0, fifo_Count}, 0);
        chk("rst_flags", {29'd0, rct_Fail, apt_Fail, overflow}, 0);
        chk("rst_byte", {24'd0, out_Byte}, 0);
        reset = 1'b1;
        out_Ready = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        startup(8'h00);
        step(1'b1, 8'h10, 1'b0);
        chk("first_valid", {31'd0, out_Valid}, 1);
        chk("first_byte", {24'd0, out_Byte}, 32'h10);
        step(1'b1, 8'h11, 1'b0);
        chk("pushpop_byte", {24'd0, out_Byte}, 32'h11);
        chk("pushpop_count", {29'd0, fifo_Count}, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hA5, 1'b0);
            chk("rct_pass_valid", {31'd0, out_Valid}, 1);
            chk("rct_pass_byte", {24'd0, out_Byte}, 32'hA5);
            chk("rct_pass_flag", {31'd0, rct_Fail}, 0);
        end
        step(1'b1, 8'hA5, 1'b0);
        chk("rct_fail", {31'd0, rct_Fail}, 1);
        chk("rct_apt", {31'd0, apt_Fail}, 0);
        chk("rct_flush_valid", {31'd0, out_Valid}, 0);
        chk("rct_flush_count", {29'd0, fifo_Count}, 0);
        chk("rct_health", {31'd0, health_Ok}, 0);
        step(1'b0, 8'h00, 1'b0);
        chk("rct_not_pushed", {31'd0, out_Valid}, 0);
        step(1'b0, 8'h00, 1'b1);
        chk("clear_flags", {29'd0, rct_Fail, apt_Fail, overflow}, 0);
        chk("clear_health", {31'd0, health_Ok}, 0);
        startup(8'h20);
        for (int i = 0; i <= 10; i++) begin
            step(1'b1, (i % 2 == 0) ? 8'h3C : 8'h40 + 8'(i), 1'b0);
            if (i == 8) chk("apt_five", {31'd0, apt_Fail}, 0);
            if (i == 8) chk("apt_five_health", {31'd0, health_Ok}, 1);
        end
        chk("apt_fail", {31'd0, apt_Fail}, 1);
        chk("apt_rct", {31'd0, rct_Fail}, 0);
        chk("apt_health", {31'd0, health_Ok}, 0);
        chk("apt_flush", {31'd0, out_Valid}, 0);
        step(1'b1, 8'h77, 1'b0);
        chk("fail_ignore_in", {29'd0, fifo_Count}, 0);
        step(1'b0, 8'h00, 1'b1);
        chk("clear2_flags", {29'd0, rct_Fail, apt_Fail, overflow}, 0);
        startup(8'h50);
        out_Ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 8'h61 + 8'(i), 1'b0);
        chk("bp_full", {29'd0, fifo_Count}, 4);
        chk("bp_no_ovf", {31'd0, overflow}, 0);
        chk("bp_hold", {24'd0, out_Byte}, 32'h61);
        out_Ready = 1'b1;
        step(1'b1, 8'h65, 1'b0);
        chk("full_pushpop_count", {29'd0, fifo_Count}, 4);
        chk("full_pushpop_ovf", {31'd0, overflow}, 0);
        chk("full_pushpop_byte", {24'd0, out_Byte}, 32'h62);
        out_Ready = 1'b0;
        step(1'b1, 8'h66, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 1);
        chk("ovf_count", {29'd0, fifo_Count}, 4);
        step(1'b1, 8'h67, 1'b0);
        chk("ovf_count2", {29'd0, fifo_Count}, 4);
        out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_byte", {24'd0, out_Byte}, 32'h62 + i);
            step(1'b0, 8'h00, 1'b0);
        end
        chk("drain_empty", {29'd0, fifo_Count}, 0);
        chk("drain_valid", {31'd0, out_Valid}, 0);
        out_Ready = 1'b0;
        step(1'b1, 8'h70, 1'b0);
        chk("pre_areset_valid", {31'd0, out_Valid}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_health", {31'd0, health_Ok}, 0);
        chk("areset_valid", {31'd0, out_Valid}, 0);
        chk("areset_count", {29'd0, fifo_Count}, 0);
        chk("areset_flags", {29'd0, rct_Fail, apt_Fail, overflow}, 0);
        chk("areset_byte", {24'd0, out_Byte}, 0);
        #10;
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chk("post_areset_health", {31'd0, health_Ok}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
